// File: rtl/vga_timing_pkg.sv
// +----------------------------------------------------------------------------+
// | vga_timing_pkg : shared constants, scan states and width helper            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    // Smallest counter width able to hold both HTOTAL-1 and VTOTAL-1.
    function automatic int cw_for(input int h_total, input int v_total);
        int m;
        m = ((h_total > v_total) ? h_total : v_total) - 1;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_delay.sv
// +----------------------------------------------------------------------------+
// | vga_sync_delay : tick-enabled shift register with a reset fill value       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int           DEPTH = 1,
    parameter int           W     = 3,
    parameter logic [W-1:0] FILL  = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_tick,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout
);

    logic [DEPTH-1:0][W-1:0] stage_q;
    logic [DEPTH-1:0][W-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (i_tick) begin
            stage_d[0] = i_din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= {DEPTH{FILL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_dout = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// +----------------------------------------------------------------------------+
// | vga_timing_gen : parametrised VGA raster timing with frame-aligned enable  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIPE_DLY  = 0,
    parameter int CW        = DEF_CW
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    input  logic          enable,
    output logic          pixel_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic          active
);

    localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(VTOTAL - 1);
    localparam logic [CW-1:0] X_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] Y_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic          pixel_tick_q, pixel_tick_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    scan_state_e   state_q, state_d;
    logic          vid_q, vid_d, hs_q, hs_d, vs_q, vs_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic          w_x_wrap, w_frame_wrap;
    logic [CW-1:0] w_x_inc, w_y_inc;
    logic [2:0]    w_dec_raw, w_dec_out;

    always_comb begin
        pixel_tick_d = (div_q == DIV_LAST);
        div_d        = pixel_tick_d ? '0 : div_q + 1'b1;
    end

    assign w_x_wrap     = (x_q == X_LAST);
    assign w_frame_wrap = w_x_wrap && (y_q == Y_LAST);
    assign w_x_inc      = w_x_wrap ? '0 : x_q + 1'b1;
    assign w_y_inc      = !w_x_wrap ? y_q : ((y_q == Y_LAST) ? '0 : y_q + 1'b1);

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        vid_d         = vid_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pixel_tick_q) begin
            case (state_q)
                IDLE: begin
                    x_d = '0;
                    y_d = '0;
                    if (enable) begin
                        state_d       = RUN;
                        line_start_d  = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end
                RUN: begin
                    x_d           = w_x_inc;
                    y_d           = w_y_inc;
                    line_start_d  = w_x_wrap;
                    frame_start_d = w_frame_wrap;
                    if (!enable) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    x_d          = w_x_inc;
                    y_d          = w_y_inc;
                    line_start_d = w_x_wrap;
                    if (enable) begin
                        state_d       = RUN;
                        frame_start_d = w_frame_wrap;
                    end else if (w_frame_wrap) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end
            endcase
            // Decode follows the count being loaded so it lines up with x/y.
            if (state_d == IDLE) begin
                vid_d = 1'b0;
                hs_d  = ~HSYNC_POL;
                vs_d  = ~VSYNC_POL;
            end else begin
                vid_d = (x_d < X_VIS) && (y_d < Y_VIS);
                hs_d  = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
                vs_d  = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            pixel_tick_q  <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            state_q       <= IDLE;
            vid_q         <= 1'b0;
            hs_q          <= ~HSYNC_POL;
            vs_q          <= ~VSYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pixel_tick_q  <= pixel_tick_d;
            x_q           <= x_d;
            y_q           <= y_d;
            state_q       <= state_d;
            vid_q         <= vid_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign w_dec_raw = {vid_q, hs_q, vs_q};

    generate
        if (PIPE_DLY > 0) begin : g_pipe
            vga_sync_delay #(
                .DEPTH (PIPE_DLY),
                .W     (3),
                .FILL  ({1'b0, ~HSYNC_POL, ~VSYNC_POL})
            ) u_sync_delay (
                .clk    (clk_100MHz),
                .rst    (reset),
                .i_tick (pixel_tick_q),
                .i_din  (w_dec_raw),
                .o_dout (w_dec_out)
            );
        end else begin : g_direct
            assign w_dec_out = w_dec_raw;
        end
    endgenerate

    assign pixel_tick  = pixel_tick_q;
    assign x           = x_q;
    assign y           = y_q;
    assign {video_on, hsync, vsync} = w_dec_out;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign active      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// +----------------------------------------------------------------------------+
// | tb_vga_timing_gen : scoreboard bench for two small raster configurations   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        logic        tick;
        logic [15:0] x;
        logic [15:0] y;
        logic        vid;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic        act;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t got=%0h exp=%0h", name, id, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CD = (g == 0) ? 1 : 3;
        localparam int HA = (g == 0) ? 8 : 10;
        localparam int HF = 2;
        localparam int HS = (g == 0) ? 2 : 3;
        localparam int HB = (g == 0) ? 2 : 1;
        localparam int VA = (g == 0) ? 4 : 5;
        localparam int VF = (g == 0) ? 1 : 2;
        localparam int VS = 1;
        localparam int VB = (g == 0) ? 1 : 2;
        localparam bit HP = (g == 0);
        localparam bit VP = (g != 0);
        localparam int PD = (g == 0) ? 0 : 2;
        localparam int HT = HA + HF + HS + HB;
        localparam int VT = VA + VF + VS + VB;
        localparam int FT = HT * VT;
        localparam int CWG = cw_for(HT, VT);
        localparam logic [2:0] INACT = {1'b0, !HP, !VP};

        logic           pixel_tick, video_on, hsync, vsync, line_start, frame_start, active;
        logic [CWG-1:0] x, y;

        vga_timing_gen #(
            .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
            .HSYNC_POL(HP), .VSYNC_POL(VP), .PIPE_DLY(PD), .CW(CWG)
        ) dut (
            .clk_100MHz (clk),
            .reset      (reset),
            .enable     (enable),
            .pixel_tick (pixel_tick),
            .x          (x),
            .y          (y),
            .video_on   (video_on),
            .hsync      (hsync),
            .vsync      (vsync),
            .line_start (line_start),
            .frame_start(frame_start),
            .active     (active)
        );

        exp_t sbq[$];

        function automatic logic [2:0] decode(input int p);
            int px, py;
            px = p % HT;
            py = p / HT;
            decode[2] = (px < HA) && (py < VA);
            decode[1] = (px >= HA + HF && px < HA + HF + HS) ? HP : !HP;
            decode[0] = (py >= VA + VF && py < VA + VF + VS) ? VP : !VP;
        endfunction

        // Reference: frame position p as a linear pixel index, mode 0/1/2 = idle/run/drain.
        initial begin : p_model
            int n, mode, p;
            logic [2:0] hist[$];
            logic ls, fs;
            exp_t e;
            n = 0; mode = 0; p = 0;
            forever begin
                @(posedge clk);
                ls = 1'b0;
                fs = 1'b0;
                if (reset) begin
                    n = 0; mode = 0; p = 0;
                    hist = {};
                    repeat (PD + 1) hist.push_back(INACT);
                end else begin
                    n++;
                    if (n >= 2 && (n - 1) % CD == 0) begin
                        case (mode)
                            0: if (enable) begin mode = 1; p = 0; fs = 1'b1; ls = 1'b1; end
                            1: begin
                                p  = (p + 1) % FT;
                                ls = (p % HT == 0);
                                fs = (p == 0);
                                if (!enable) mode = 2;
                            end
                            default: begin
                                p  = (p + 1) % FT;
                                ls = (p % HT == 0);
                                if (enable) begin mode = 1; fs = (p == 0); end
                                else if (p == 0) mode = 0;
                            end
                        endcase
                        hist.push_back((mode == 0) ? INACT : decode(p));
                        if (hist.size() > PD + 1) void'(hist.pop_front());
                    end
                end
                e.tick = !reset && (n % CD == 0);
                e.x    = 16'((mode == 0) ? 0 : p % HT);
                e.y    = 16'((mode == 0) ? 0 : p / HT);
                {e.vid, e.hs, e.vs} = hist[0];
                e.ls   = ls;
                e.fs   = fs;
                e.act  = (mode != 0);
                sbq.push_back(e);
            end
        end

        initial begin : p_monitor
            exp_t e;
            forever begin
                @(negedge clk);
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty dut%0d t=%0t got=no_expectation exp=one_per_cycle", g, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("pixel_tick",  g, 32'(pixel_tick),  32'(e.tick));
                    chk("x",           g, 32'(x),           32'(e.x));
                    chk("y",           g, 32'(y),           32'(e.y));
                    chk("video_on",    g, 32'(video_on),    32'(e.vid));
                    chk("hsync",       g, 32'(hsync),       32'(e.hs));
                    chk("vsync",       g, 32'(vsync),       32'(e.vs));
                    chk("line_start",  g, 32'(line_start),  32'(e.ls));
                    chk("frame_start", g, 32'(frame_start), 32'(e.fs));
                    chk("active",      g, 32'(active),      32'(e.act));
                end
            end
        end

        // Asynchronous reset must clear outputs before the next clock edge.
        initial begin : p_async_reset
            forever begin
                @(posedge reset);
                #1;
                chk("rst_tick",  g, 32'(pixel_tick),  32'(0));
                chk("rst_x",     g, 32'(x),           32'(0));
                chk("rst_y",     g, 32'(y),           32'(0));
                chk("rst_video", g, 32'(video_on),    32'(0));
                chk("rst_hsync", g, 32'(hsync),       32'(!HP));
                chk("rst_vsync", g, 32'(vsync),       32'(!VP));
                chk("rst_ls",    g, 32'(line_start),  32'(0));
                chk("rst_fs",    g, 32'(frame_start), 32'(0));
                chk("rst_act",   g, 32'(active),      32'(0));
            end
        end
    end

    initial begin : p_stimulus
        reset  = 1'b0;
        enable = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        for (int s = 0; s < 26; s++) begin
            enable = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 450)) @(negedge clk);
            #1;
            if (s == 8 || s == 17) begin
                reset = 1'b1;
                repeat (2) @(negedge clk);
                #1 reset = 1'b0;
            end
        end
        enable = 1'b1;
        repeat (700) @(negedge clk);
        enable = 1'b0;
        repeat (700) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
